// File: rtl/layer_sequencer.sv
// Layer-by-layer sequencer: walks a small per-layer configuration table and
// presents each layer's parameters to the scale stage, handshaking per layer.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a transmission_start rising edge; table writable
// INIT  | init raised toward data transmission, waiting for start ack
// LOAD  | one cycle: register table[layer_num] onto the field outputs
// RUN   | layer in progress; layer_ready sampled from 2nd RUN cycle on
// DONE  | last layer finished; outputs hold, table writable, restartable
module layer_sequencer #(
  parameter int LAYER_NUM_WIDTH = 3,
  parameter int LAYER_COUNT     = 4,
  parameter int CFG_WIDTH       = 49
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       transmission_start,
  input  logic                       start,
  input  logic                       layer_ready,
  input  logic                       cfg_we,
  input  logic [LAYER_NUM_WIDTH-1:0] cfg_addr,
  input  logic [CFG_WIDTH-1:0]       cfg_data,
  output logic                       cfg_reject,
  output logic                       init,
  output logic [LAYER_NUM_WIDTH-1:0] layer_num,
  output logic [1:0]                 layer_type,
  output logic [1:0]                 pre_layer_type,
  output logic [7:0]                 fm_size,
  output logic [9:0]                 fm_depth,
  output logic [7:0]                 fm_size_out,
  output logic [1:0]                 padding_out,
  output logic [9:0]                 kernel_num,
  output logic [3:0]                 kernel_size,
  output logic                       pool_type,
  output logic [2:0]                 pool_win_size,
  output logic                       activation,
  output logic                       layer_start,
  output logic                       busy,
  output logic                       done
);

  localparam int AW    = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1;
  localparam int DEPTH = 2 ** AW;
  localparam logic [LAYER_NUM_WIDTH-1:0] LAST = LAYER_NUM_WIDTH'(LAYER_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state;
  logic                 ts_q;
  logic                 start_edge;
  logic                 cfg_ok;
  logic [CFG_WIDTH-1:0] cfg_tbl [DEPTH];
  logic [CFG_WIDTH-1:0] entry;

  assign start_edge = transmission_start & ~ts_q;
  assign cfg_ok     = ((state == S_IDLE) || (state == S_DONE)) &&
                      (int'(cfg_addr) < LAYER_COUNT);
  assign entry      = cfg_tbl[layer_num[AW-1:0]];

  // Address is range-checked before the truncated index is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cfg_tbl[i] <= '0;
      cfg_reject <= 1'b0;
    end else begin
      cfg_reject <= cfg_we & ~cfg_ok;
      if (cfg_we && cfg_ok) cfg_tbl[cfg_addr[AW-1:0]] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      ts_q           <= 1'b0;
      init           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      layer_start    <= 1'b0;
      layer_num      <= '0;
      pre_layer_type <= '0;
      layer_type     <= '0;
      fm_size        <= '0;
      fm_depth       <= '0;
      fm_size_out    <= '0;
      padding_out    <= '0;
      kernel_num     <= '0;
      kernel_size    <= '0;
      pool_type      <= 1'b0;
      pool_win_size  <= '0;
      activation     <= 1'b0;
    end else begin
      ts_q        <= transmission_start;
      layer_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            state          <= S_INIT;
            init           <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            layer_num      <= '0;
            pre_layer_type <= '0;
          end
        end
        S_INIT: begin
          if (start) begin
            state <= S_LOAD;
            init  <= 1'b0;
          end
        end
        S_LOAD: begin
          layer_type    <= entry[1:0];
          fm_size       <= entry[9:2];
          fm_depth      <= entry[19:10];
          fm_size_out   <= entry[27:20];
          padding_out   <= entry[29:28];
          kernel_num    <= entry[39:30];
          kernel_size   <= entry[43:40];
          pool_type     <= entry[44];
          pool_win_size <= entry[47:45];
          activation    <= entry[48];
          layer_start   <= 1'b1;
          state         <= S_RUN;
        end
        S_RUN: begin
          // layer_start marks the first RUN cycle, where layer_ready is stale.
          if (!layer_start && layer_ready) begin
            if (layer_num == LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pre_layer_type <= layer_type;
              layer_num      <= layer_num + 1'b1;
              state          <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
